// File: rtl/rr_onehot_arb_if.sv
// Request/grant bundle between requesters and the round-robin arbiter.
//   req     : per-requester request bits (bit i = requester i wants the path)
//   done    : current owner releases its grant this cycle
//   gnt     : registered one-hot grant, drives the downstream mux select
//   gnt_id  : binary index of the set gnt bit (0 when idle)
//   busy    : high whenever gnt is non-zero
//   timeout : one-cycle pulse after a grant is revoked by hold-time expiry
// Modport master belongs to the requester side; slave belongs to the arbiter.
interface rr_onehot_arb_if;
    logic [3:0] req;
    logic       done;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       busy;
    logic       timeout;

    modport master (
        output req,
        output done,
        input  gnt,
        input  gnt_id,
        input  busy,
        input  timeout
    );

    modport slave (
        input  req,
        input  done,
        output gnt,
        output gnt_id,
        output busy,
        output timeout
    );
endinterface

// File: rtl/rr_onehot_arb.sv
// Four-way round-robin arbiter with a registered one-hot grant and a bounded hold time.
// Ports:
//   clk : sole clock, rising edge
//   rst : synchronous active-high reset
//   arb : rr_onehot_arb_if.slave bundle (req/done in; gnt/gnt_id/busy/timeout out)
// Parameter MAX_HOLD (1..255) caps the number of consecutive cycles one grant may last.
module rr_onehot_arb #(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic            clk,
    input  logic            rst,
    rr_onehot_arb_if.slave  arb
);

    localparam int unsigned HcntW = $clog2(MAX_HOLD + 1);
    localparam logic [HcntW-1:0] HoldMax = HcntW'(MAX_HOLD);
    localparam logic [HcntW-1:0] HcntOne = HcntW'(1);

    typedef enum logic [0:0] {StIdle, StOwned} state_e;

    state_e           state_q, state_d;
    logic [3:0]       gnt_q, gnt_d;
    logic [1:0]       gnt_id_q, gnt_id_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [HcntW-1:0] hcnt_q, hcnt_d;
    logic             timeout_q, timeout_d;

    logic             vol_rel;
    logic             expired;
    logic             release_now;
    logic [1:0]       arb_ptr;
    logic [1:0]       win_id;

    // First set request scanning p, p+1, p+2, p+3 (mod 4). Descending loop so the
    // smallest offset from p overwrites any later candidate.
    function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] p);
        logic [1:0] idx;
        pick = p;
        for (int i = 3; i >= 0; i--) begin
            idx = p + 2'(i);
            if (r[idx]) begin
                pick = idx;
            end
        end
    endfunction

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        gnt_id_d  = gnt_id_q;
        ptr_d     = ptr_q;
        hcnt_d    = hcnt_q;
        timeout_d = 1'b0;

        vol_rel     = arb.done | ~arb.req[gnt_id_q];
        expired     = (hcnt_q == HoldMax);
        release_now = (state_q == StOwned) & (vol_rel | expired);
        // On release the pointer moves past the owner before this edge's arbitration.
        arb_ptr     = release_now ? (gnt_id_q + 2'd1) : ptr_q;
        win_id      = pick(arb.req, arb_ptr);

        unique case (state_q)
            StIdle: begin
                if (|arb.req) begin
                    state_d  = StOwned;
                    gnt_d    = 4'b0001 << win_id;
                    gnt_id_d = win_id;
                    hcnt_d   = HcntOne;
                end
            end
            StOwned: begin
                if (release_now) begin
                    ptr_d = arb_ptr;
                    // A voluntary release in the expiry cycle wins over the timeout.
                    timeout_d = expired & ~vol_rel;
                    if (|arb.req) begin
                        gnt_d    = 4'b0001 << win_id;
                        gnt_id_d = win_id;
                        hcnt_d   = HcntOne;
                    end else begin
                        state_d  = StIdle;
                        gnt_d    = 4'b0000;
                        gnt_id_d = 2'd0;
                    end
                end else begin
                    hcnt_d = hcnt_q + HcntOne;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            gnt_q     <= 4'b0000;
            gnt_id_q  <= 2'd0;
            ptr_q     <= 2'd0;
            hcnt_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            gnt_id_q  <= gnt_id_d;
            ptr_q     <= ptr_d;
            hcnt_q    <= hcnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign arb.gnt     = gnt_q;
    assign arb.gnt_id  = gnt_id_q;
    assign arb.busy    = |gnt_q;
    assign arb.timeout = timeout_q;

endmodule

// File: tb/tb_rr_onehot_arb.sv
// Self-checking bench for rr_onehot_arb. Three instances (MAX_HOLD = 8, 2, 1) share
// the same stimulus; a behavioural model predicts each instance's outputs, expected
// values are queued before each edge and compared after it. Directed checks cover the
// named scenarios, and a negedge monitor checks one-hot/gnt_id/busy consistency.
module tb_rr_onehot_arb;

    logic       clk  = 1'b0;
    logic       rst  = 1'b1;
    logic [3:0] req  = 4'b0000;
    logic       done = 1'b0;
    logic       chk_on = 1'b0;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    rr_onehot_arb_if u8 ();
    rr_onehot_arb_if u2 ();
    rr_onehot_arb_if u1 ();

    assign u8.req = req;
    assign u8.done = done;
    assign u2.req = req;
    assign u2.done = done;
    assign u1.req = req;
    assign u1.done = done;

    rr_onehot_arb #(.MAX_HOLD(8)) dut8 (.clk(clk), .rst(rst), .arb(u8.slave));
    rr_onehot_arb #(.MAX_HOLD(2)) dut2 (.clk(clk), .rst(rst), .arb(u2.slave));
    rr_onehot_arb #(.MAX_HOLD(1)) dut1 (.clk(clk), .rst(rst), .arb(u1.slave));

    typedef struct packed {
        logic [3:0] gnt;
        logic [1:0] id;
        logic [1:0] ptr;
        int         hcnt;
        logic       owned;
        logic       to;
    } m_t;

    typedef struct {
        int         d;
        logic [3:0] gnt;
        logic [1:0] id;
        logic       busy;
        logic       to;
    } exp_t;

    exp_t sb[$];
    m_t   mdl[3];
    int   mh[3] = '{8, 2, 1};

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_total++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Grant to the first requester at or after p (mod 4).
    function automatic m_t m_grant(input m_t s, input logic [3:0] rq, input int p);
        m_t n = s;
        for (int k = 0; k < 4; k++) begin
            int c = (p + k) % 4;
            if (rq[c]) begin
                n.id  = 2'(c);
                n.gnt = 4'(1 << c);
                break;
            end
        end
        n.owned = 1'b1;
        n.hcnt  = 1;
        return n;
    endfunction

    function automatic m_t m_step(input m_t s, input logic r, input logic [3:0] rq,
                                  input logic dn, input int maxh);
        m_t n = s;
        bit vol;
        bit exp_hit;
        n.to = 1'b0;
        if (r) return '0;
        if (!s.owned) begin
            if (rq != 4'b0000) n = m_grant(n, rq, int'(s.ptr));
        end else begin
            vol     = dn || !rq[s.id];
            exp_hit = (s.hcnt == maxh);
            if (vol || exp_hit) begin
                n.to  = exp_hit && !vol;
                n.ptr = 2'((int'(s.id) + 1) % 4);
                if (rq != 4'b0000) begin
                    n = m_grant(n, rq, int'(n.ptr));
                end else begin
                    n.owned = 1'b0;
                    n.gnt   = 4'b0000;
                    n.id    = 2'd0;
                end
            end else begin
                n.hcnt = s.hcnt + 1;
            end
        end
        return n;
    endfunction

    function automatic exp_t observe(input int d);
        exp_t o;
        o.d = d;
        case (d)
            0: begin o.gnt = u8.gnt; o.id = u8.gnt_id; o.busy = u8.busy; o.to = u8.timeout; end
            1: begin o.gnt = u2.gnt; o.id = u2.gnt_id; o.busy = u2.busy; o.to = u2.timeout; end
            default: begin
                o.gnt = u1.gnt; o.id = u1.gnt_id; o.busy = u1.busy; o.to = u1.timeout;
            end
        endcase
        return o;
    endfunction

    // One clock: predict with current inputs, let the edge happen, compare.
    task automatic cycle();
        exp_t e;
        exp_t o;
        for (int d = 0; d < 3; d++) begin
            mdl[d] = m_step(mdl[d], rst, req, done, mh[d]);
            sb.push_back('{d, mdl[d].gnt, mdl[d].id, |mdl[d].gnt, mdl[d].to});
        end
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            o = observe(e.d);
            check_eq($sformatf("sb%0d.gnt", mh[e.d]), 8'(o.gnt), 8'(e.gnt));
            check_eq($sformatf("sb%0d.gnt_id", mh[e.d]), 8'(o.id), 8'(e.id));
            check_eq($sformatf("sb%0d.busy", mh[e.d]), 8'(o.busy), 8'(e.busy));
            check_eq($sformatf("sb%0d.timeout", mh[e.d]), 8'(o.to), 8'(e.to));
        end
    endtask

    // Structural invariant on every instance, every cycle.
    always @(negedge clk) begin
        if (chk_on) begin
            for (int d = 0; d < 3; d++) begin
                exp_t o;
                logic [1:0] want_id;
                o = observe(d);
                want_id = 2'd0;
                for (int b = 0; b < 4; b++) begin
                    if (o.gnt[b]) want_id = 2'(b);
                end
                check_eq($sformatf("inv%0d.onehot0", mh[d]), 8'($onehot0(o.gnt)), 8'd1);
                check_eq($sformatf("inv%0d.gnt_id", mh[d]), 8'(o.id), 8'(want_id));
                check_eq($sformatf("inv%0d.busy", mh[d]), 8'(o.busy), 8'(|o.gnt));
            end
        end
    end

    initial begin
        for (int d = 0; d < 3; d++) mdl[d] = '0;

        // Reset overrides pending requests.
        rst = 1'b1; req = 4'b1111; done = 1'b0;
        cycle();
        cycle();
        chk_on = 1'b1;
        check_eq("rst.gnt", 8'(u8.gnt), 8'h00);
        check_eq("rst.busy", 8'(u8.busy), 8'h00);
        check_eq("rst.timeout", 8'(u8.timeout), 8'h00);

        // Sole requester 2: grant after one edge, held 8 cycles, expiry, regrant.
        rst = 1'b0; req = 4'b0100;
        cycle();
        check_eq("single.gnt", 8'(u8.gnt), 8'h04);
        check_eq("single.gnt_id", 8'(u8.gnt_id), 8'd2);
        for (int k = 0; k < 7; k++) begin
            cycle();
            check_eq("single.hold", 8'(u8.gnt), 8'h04);
            check_eq("single.no_to", 8'(u8.timeout), 8'h00);
        end
        cycle();
        check_eq("single.timeout", 8'(u8.timeout), 8'h01);
        check_eq("single.regrant", 8'(u8.gnt), 8'h04);
        cycle();
        check_eq("single.to_pulse", 8'(u8.timeout), 8'h00);

        // Rotation with done on each grant's first cycle.
        rst = 1'b1; cycle();
        rst = 1'b0; req = 4'b1111;
        cycle();
        check_eq("rot.first", 8'(u8.gnt), 8'h01);
        for (int k = 1; k <= 4; k++) begin
            done = 1'b1;
            cycle();
            check_eq("rot.order", 8'(u8.gnt), 8'(1 << (k % 4)));
        end
        done = 1'b0;

        // MAX_HOLD = 1: strict rotation under continuous requests.
        rst = 1'b1; cycle();
        rst = 1'b0; req = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            cycle();
            check_eq("hold1.rot", 8'(u1.gnt), 8'(1 << (k % 4)));
        end

        // Owner 1 loses its request: requester 0 granted without timeout.
        rst = 1'b1; cycle();
        rst = 1'b0; req = 4'b0011;
        cycle();
        done = 1'b1;
        cycle();
        check_eq("drop.owner1", 8'(u8.gnt), 8'h02);
        done = 1'b0; req = 4'b0001;
        cycle();
        check_eq("drop.gnt", 8'(u8.gnt), 8'h01);
        check_eq("drop.timeout", 8'(u8.timeout), 8'h00);

        // MAX_HOLD = 2: done coincides with expiry -> voluntary; then a real expiry.
        rst = 1'b1; cycle();
        rst = 1'b0; req = 4'b0001;
        cycle();
        cycle();
        done = 1'b1;
        cycle();
        check_eq("both.timeout", 8'(u2.timeout), 8'h00);
        check_eq("both.regrant", 8'(u2.gnt), 8'h01);
        done = 1'b0;
        cycle();
        cycle();
        check_eq("expire2.timeout", 8'(u2.timeout), 8'h01);

        // Mid-grant reset of owner 3, then requester 0 favoured.
        rst = 1'b1; cycle();
        rst = 1'b0; req = 4'b1000;
        cycle();
        check_eq("midrst.owner3", 8'(u8.gnt), 8'h08);
        rst = 1'b1; req = 4'b1001;
        cycle();
        check_eq("midrst.gnt", 8'(u8.gnt), 8'h00);
        check_eq("midrst.busy", 8'(u8.busy), 8'h00);
        check_eq("midrst.timeout", 8'(u8.timeout), 8'h00);
        rst = 1'b0;
        cycle();
        check_eq("midrst.first", 8'(u8.gnt), 8'h01);

        // Random traffic against the model.
        for (int k = 0; k < 300; k++) begin
            rst  = ($urandom_range(39) == 0);
            req  = 4'($urandom);
            done = ($urandom_range(3) == 0);
            cycle();
        end

        chk_on = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/rr_onehot_arb.md
RR_ONEHOT_ARB -- requirements
Module: rr_onehot_arb

Interface
REQ-001 The block SHALL have one parameter: MAX_HOLD, default 8, the maximum number of consecutive cycles one grant may be held (legal range 1..255).
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 req  input  4  per-requester request bits; bit i means requester i wants the shared path.
REQ-005 done  input  1  current owner releases its grant this cycle; ignored when no grant is active.
REQ-006 gnt  output  4  registered one-hot grant; drives the select of the downstream one-hot mux directly.
REQ-007 gnt_id  output  2  binary index of the set gnt bit; 0 when gnt is 0.
REQ-008 busy  output  1  high whenever gnt is non-zero.
REQ-009 timeout  output  1  single-cycle pulse when a grant is forcibly revoked by MAX_HOLD expiry.

Function
REQ-010 gnt SHALL be 4'b0000 or exactly one-hot in every cycle; no other pattern is permitted.
REQ-011 The block SHALL implement two states: IDLE (gnt=0) and OWNED (gnt one-hot).
REQ-012 State SHALL include a 2-bit priority pointer ptr and a hold counter hcnt sized for 0..MAX_HOLD.
REQ-013 Arbitration SHALL select the first set req bit scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4).
REQ-014 IDLE -> OWNED: when req != 0 at a rising edge, gnt SHALL show the selected requester from the next cycle (latency 1), and hcnt SHALL load 1.
REQ-015 IDLE with req == 0 SHALL stay IDLE; ptr and hcnt SHALL be unchanged.
REQ-016 In OWNED, a release SHALL occur at an edge where any of the following holds: done=1; req[gnt_id]=0; hcnt==MAX_HOLD.
REQ-017 In OWNED with no release condition, gnt SHALL hold and hcnt SHALL increment by 1.
REQ-018 On release, ptr SHALL be set to gnt_id+1 (mod 4). Arbitration SHALL re-run in the same edge using the new ptr and current req.
REQ-019 After a release with any req bit set, the new grant SHALL appear in the next cycle with no idle bubble, and hcnt SHALL load 1.
REQ-020 After a release with req all zero, the block SHALL return to IDLE.
REQ-021 The releasing owner SHALL be regranted if it is the only requester.
REQ-022 timeout SHALL pulse high for exactly the cycle after a release caused solely by hcnt==MAX_HOLD.
REQ-023 If done=1 or req[gnt_id]=0 in the same cycle that hcnt==MAX_HOLD, the release SHALL count as voluntary and timeout SHALL stay 0.
REQ-024 With MAX_HOLD=1, each grant SHALL last exactly one cycle and strict rotation SHALL occur under continuous requests.
REQ-025 Under continuous requests from all four requesters, every requester SHALL receive a grant within 3*MAX_HOLD+1 cycles of its request.
REQ-026 gnt_id, busy and timeout SHALL be registered, or derived combinationally only from registered state.

Reset
REQ-027 While rst=1 at an edge: gnt=0, gnt_id=0, busy=0, timeout=0, ptr=0, hcnt=0, and state=IDLE, regardless of current state or inputs.
REQ-028 Reset asserted mid-grant SHALL drop gnt to 0 in the next cycle with no timeout pulse.
REQ-029 The first arbitration after reset SHALL favour requester 0.

Verification
REQ-030 Single request: after reset, req=4'b0100 held, done=0, MAX_HOLD=8 -> gnt=4'b0100 and gnt_id=2 one cycle later; gnt held 8 cycles; then timeout pulses once and gnt=4'b0100 again (sole requester regranted).
REQ-031 Rotation: req=4'b1111 constant, done pulsed on each grant's first cycle -> grant order 0,1,2,3,0 with no zero-gnt cycle between grants.
REQ-032 Request drop: owner 1 with req=4'b0011; req[1] falls -> next cycle gnt=4'b0001, timeout=0; ptr now favours 2.
REQ-033 Simultaneous done and expiry: MAX_HOLD=2, done=1 in the second grant cycle -> release occurs, timeout stays 0.
REQ-034 Mid-grant reset: owner 3, rst=1 for one edge -> gnt=0 and busy=0 next cycle; with req=4'b1001 after reset, requester 0 is granted first.
REQ-035 A bench assertion SHALL check one-hot-or-zero gnt and gnt_id/busy consistency in every cycle across all scenarios.
